// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with frame, bit strobe and end-of-word latch pulse.
// Words are taken over a valid/ready handshake and sent one bit per CLK_DIV clocks.
module piso_serializer #(
    parameter int WIDTH     = 16,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             frame_o,
    output logic             strobe_o,
    output logic             latch_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             ready_q, ready_d;
    logic             data_q, data_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d   = S_SHIFT;
                    shreg_d   = data_i;
                    bit_cnt_d = BIT_LAST;
                    div_cnt_d = DIV_LAST;
                end
            end
            S_SHIFT: begin
                if (div_cnt_q == '0) begin
                    if (bit_cnt_q == '0) begin
                        state_d   = S_LATCH;
                        shreg_d   = '0;
                        div_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        div_cnt_d = DIV_LAST;
                        shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1)
                                                     : (shreg_q >> 1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            S_LATCH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Head of the shift register is the bit on the wire next cycle.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        data_d  = 1'b0;
        if (state_d == S_SHIFT)
            data_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ready_q   <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
        end
    end

    assign ready_o  = ready_q;
    assign data_o   = data_q;
    assign frame_o  = (state_q == S_SHIFT);
    assign strobe_o = (state_q == S_SHIFT) && (div_cnt_q == '0);
    assign latch_o  = (state_q == S_LATCH);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three parameterisations share clock and reset.
// Each sample is taken on the falling edge, inputs change on the falling edge.
module tb_piso_serializer;

    logic clk;
    logic reset_n;

    logic [7:0]  data_a, data_b;
    logic [15:0] data_c;
    logic valid_a, valid_b, valid_c;
    logic ready_a, ready_b, ready_c;
    logic dout_a, dout_b, dout_c;
    logic frame_a, frame_b, frame_c;
    logic strobe_a, strobe_b, strobe_c;
    logic latch_a, latch_b, latch_c;

    int checks;
    int errors;

    piso_serializer #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .reset_n(reset_n), .data_i(data_a), .valid_i(valid_a),
        .ready_o(ready_a), .data_o(dout_a), .frame_o(frame_a),
        .strobe_o(strobe_a), .latch_o(latch_a)
    );

    piso_serializer #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(0)) u_b (
        .clk(clk), .reset_n(reset_n), .data_i(data_b), .valid_i(valid_b),
        .ready_o(ready_b), .data_o(dout_b), .frame_o(frame_b),
        .strobe_o(strobe_b), .latch_o(latch_b)
    );

    piso_serializer u_c (
        .clk(clk), .reset_n(reset_n), .data_i(data_c), .valid_i(valid_c),
        .ready_o(ready_c), .data_o(dout_c), .frame_o(frame_c),
        .strobe_o(strobe_c), .latch_o(latch_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("excl_a", {31'd0, ready_a & (frame_a | strobe_a | latch_a)}, 0);
            chk("excl_b", {31'd0, ready_b & (frame_b | strobe_b | latch_b)}, 0);
            chk("excl_c", {31'd0, ready_c & (frame_c | strobe_c | latch_c)}, 0);
        end
    end

    // Full word on u_c (16 bits, 4 clocks per bit, MSB first).
    task automatic send_c(input logic [15:0] w, input string tag);
        logic eb;
        data_c  = w;
        valid_c = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (c == 1) valid_c = 1'b0;
            if (c <= 64) begin
                eb = w[15 - (c - 1) / 4];
                chk({tag, "_dout"}, dout_c, eb);
                chk({tag, "_frame"}, frame_c, 1);
                chk({tag, "_strobe"}, strobe_c, (c % 4 == 0));
                chk({tag, "_ready"}, ready_c, 0);
            end else if (c == 65) begin
                chk({tag, "_latch"}, latch_c, 1);
                chk({tag, "_lframe"}, frame_c, 0);
                chk({tag, "_ldout"}, dout_c, 0);
            end else begin
                chk({tag, "_rdy"}, ready_c, 1);
                chk({tag, "_nolatch"}, latch_c, 0);
            end
        end
    endtask

    initial begin
        logic [7:0] w;
        logic ed, ef;
        int lat;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a  = '0;   data_b  = '0;   data_c  = '0;

        #1;
        chk("rst_ready", ready_c, 0);
        chk("rst_dout", dout_c, 0);
        chk("rst_frame", frame_c, 0);
        chk("rst_strobe", strobe_c, 0);
        chk("rst_latch", latch_c, 0);
        chk("rst_ready_a", ready_a, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_ready0", ready_a, 0);
        @(negedge clk);
        chk("rel_ready_a", ready_a, 1);
        chk("rel_ready_b", ready_b, 1);
        chk("rel_ready_c", ready_c, 1);

        // 0xA5, one clock per bit, MSB first
        w = 8'hA5;
        data_a  = w;
        valid_a = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t1_dout", dout_a, w[8 - c]);
            chk("t1_strobe", strobe_a, 1);
            chk("t1_frame", frame_a, 1);
            chk("t1_ready", ready_a, 0);
            if (c == 1) valid_a = 1'b0;
        end
        @(negedge clk);
        chk("t1_latch", latch_a, 1);
        chk("t1_lframe", frame_a, 0);
        chk("t1_lstrobe", strobe_a, 0);
        chk("t1_lready", ready_a, 0);
        @(negedge clk);
        chk("t1_ready_back", ready_a, 1);
        chk("t1_latch_off", latch_a, 0);

        // back-to-back: valid held, word swapped mid-stream
        data_a  = 8'hA5;
        valid_a = 1'b1;
        lat     = 0;
        @(posedge clk);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                w = 8'hA5; ed = w[8 - c]; ef = 1'b1;
            end else if (c <= 10) begin
                ed = 1'b0; ef = 1'b0;
            end else if (c <= 18) begin
                w = 8'h3C; ed = w[18 - c]; ef = 1'b1;
            end else begin
                ed = 1'b0; ef = 1'b0;
            end
            chk("t3_dout", dout_a, ed);
            chk("t3_frame", frame_a, ef);
            if (c == 10) chk("t3_ready10", ready_a, 1);
            lat += int'(latch_a);
            if (c == 1) data_a = 8'h3C;
            if (c == 11) valid_a = 1'b0;
        end
        chk("t3_latch_count", lat, 2);
        @(negedge clk);
        chk("t3_ready", ready_a, 1);
        @(negedge clk);
        chk("t3_no_third", frame_a, 0);

        // 0x01, four clocks per bit, LSB first
        data_b  = 8'h01;
        valid_b = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 1) valid_b = 1'b0;
            if (c <= 32) begin
                chk("t2_dout", dout_b, (c <= 4));
                chk("t2_strobe", strobe_b, (c % 4 == 0));
                chk("t2_frame", frame_b, 1);
                chk("t2_latch0", latch_b, 0);
            end else if (c == 33) begin
                chk("t2_latch", latch_b, 1);
                chk("t2_lstrobe", strobe_b, 0);
                chk("t2_ldout", dout_b, 0);
            end else begin
                chk("t2_ready", ready_b, 1);
            end
        end

        // inputs toggling during SHIFT must not disturb the stream
        w = 8'h96;
        data_b  = w;
        valid_b = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c <= 32) begin
                chk("t4_dout", dout_b, w[(c - 1) / 4]);
                chk("t4_frame", frame_b, 1);
            end else if (c == 33) begin
                chk("t4_latch", latch_b, 1);
            end else begin
                chk("t4_ready", ready_b, 1);
                chk("t4_no_accept", frame_b, 0);
            end
            if (c < 32) begin
                valid_b = (c % 2 == 0);
                data_b  = ~data_b;
            end else begin
                valid_b = 1'b0;
            end
        end

        send_c(16'hC3A5, "tc");

        // reset mid-word: 3 full bits then into the 4th
        data_c  = 16'hFFFF;
        valid_c = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) valid_c = 1'b0;
            chk("t5_dout", dout_c, 1);
            chk("t5_frame", frame_c, 1);
        end
        reset_n = 1'b0;
        #1;
        chk("t5_async_dout", dout_c, 0);
        chk("t5_async_frame", frame_c, 0);
        chk("t5_async_strobe", strobe_c, 0);
        chk("t5_async_latch", latch_c, 0);
        chk("t5_async_ready", ready_c, 0);
        @(negedge clk);
        chk("t5_hold_ready", ready_c, 0);
        chk("t5_hold_latch", latch_c, 0);
        reset_n = 1'b1;
        #1 chk("t5_rel_ready0", ready_c, 0);
        @(negedge clk);
        chk("t5_rel_ready1", ready_c, 1);
        chk("t5_rel_latch", latch_c, 0);
        chk("t5_rel_frame", frame_c, 0);
        @(negedge clk);
        chk("t5_still_nolatch", latch_c, 0);

        send_c(16'h1234, "t5c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
